// File: rtl/multicycle_ctrl32_if.sv
// multicycle_ctrl32_if: instruction fields, memory handshake and datapath control strobes
interface multicycle_ctrl32_if #(parameter int CNT_W = 32);
    logic [5:0] Opcode, Function_opcode;
    logic Zero, mem_ready;
    logic PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDST, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic Jal, Sftmd, I_format, Illegal, Done;
    logic [CNT_W-1:0] InstrCount;
    logic [3:0] State;
    modport master(
        input Opcode, Function_opcode, Zero, mem_ready,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDST, MemtoReg, RegWrite, ALUSrcA,
        output ALUSrcB, ALUOp, PCSource, Jal, Sftmd, I_format, Illegal, Done, InstrCount, State
    );
    modport slave(
        output Opcode, Function_opcode, Zero, mem_ready,
        input PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDST, MemtoReg, RegWrite, ALUSrcA,
        input ALUSrcB, ALUOp, PCSource, Jal, Sftmd, I_format, Illegal, Done, InstrCount, State
    );
endinterface

// File: rtl/multicycle_ctrl32.sv
// multicycle_ctrl32: Moore FSM sequencing a shared-ALU/shared-memory MIPS datapath, with retire counter
module multicycle_ctrl32 #(parameter int CNT_W = 32) (
    input logic clock,
    input logic reset,
    multicycle_ctrl32_if.master bus
);
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                           S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_REXEC = 4'd6, S_RWB = 4'd7,
                           S_BRANCH = 4'd8, S_JUMP = 4'd9, S_IEXEC = 4'd10, S_IWB = 4'd11,
                           S_JR = 4'd12;
    logic [3:0] state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic is_r, is_jr, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_i, is_shift;
    assign is_r = bus.Opcode == 6'b000000;
    assign is_jr = is_r && bus.Function_opcode == 6'b001000;
    assign is_lw = bus.Opcode == 6'b100011;
    assign is_sw = bus.Opcode == 6'b101011;
    assign is_beq = bus.Opcode == 6'b000100;
    assign is_bne = bus.Opcode == 6'b000101;
    assign is_j = bus.Opcode == 6'b000010;
    assign is_jal = bus.Opcode == 6'b000011;
    assign is_i = bus.Opcode[5:3] == 3'b001;
    assign is_shift = bus.Function_opcode[5:3] == 3'b000;
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_d = is_jr ? S_JR : is_r ? S_REXEC : (is_lw || is_sw) ? S_MEMADR :
                                (is_beq || is_bne) ? S_BRANCH : (is_j || is_jal) ? S_JUMP :
                                is_i ? S_IEXEC : S_FETCH;
            S_MEMADR: state_d = is_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD: state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR: state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_REXEC: state_d = S_RWB;
            S_IEXEC: state_d = S_IWB;
            default: state_d = S_FETCH;
        endcase
    end
    assign cnt_d = cnt_q + CNT_W'(bus.Done);
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
        end
    end
    assign bus.State = reset ? 4'd0 : state_q;
    assign bus.InstrCount = reset ? '0 : cnt_q;
    // Everything defaults low; reset simply skips the decode so all strobes stay 0
    always_comb begin
        bus.PCWrite = 1'b0;
        bus.IorD = 1'b0;
        bus.MemRead = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IRWrite = 1'b0;
        bus.RegDST = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.RegWrite = 1'b0;
        bus.ALUSrcA = 1'b0;
        bus.ALUSrcB = 2'b00;
        bus.ALUOp = 2'b00;
        bus.PCSource = 2'b00;
        bus.Jal = 1'b0;
        bus.Sftmd = 1'b0;
        bus.I_format = 1'b0;
        bus.Illegal = 1'b0;
        bus.Done = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.IRWrite = bus.mem_ready;
                    bus.PCWrite = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.ALUSrcB = 2'b11;
                    bus.Illegal = !(is_r || is_lw || is_sw || is_beq || is_bne || is_j || is_jal || is_i);
                end
                S_MEMADR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD = 1'b1;
                end
                S_MEMWB: begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = 1'b1;
                    bus.Done = 1'b1;
                end
                S_MEMWR: begin
                    bus.MemWrite = 1'b1;
                    bus.IorD = 1'b1;
                    bus.Done = bus.mem_ready;
                end
                S_REXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp = 2'b10;
                    bus.Sftmd = is_shift;
                end
                S_RWB: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDST = 1'b1;
                    bus.Sftmd = is_shift;
                    bus.Done = 1'b1;
                end
                S_IEXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                    bus.ALUOp = 2'b11;
                    bus.I_format = 1'b1;
                end
                S_IWB: begin
                    bus.RegWrite = 1'b1;
                    bus.I_format = 1'b1;
                    bus.Done = 1'b1;
                end
                S_BRANCH: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp = 2'b01;
                    bus.PCSource = 2'b01;
                    bus.PCWrite = (is_beq && bus.Zero) || (is_bne && !bus.Zero);
                    bus.Done = 1'b1;
                end
                S_JUMP: begin
                    bus.PCWrite = 1'b1;
                    bus.PCSource = 2'b10;
                    bus.Jal = is_jal;
                    bus.RegWrite = is_jal;
                    bus.Done = 1'b1;
                end
                S_JR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.PCWrite = 1'b1;
                    bus.PCSource = 2'b11;
                    bus.Done = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/multicycle_ctrl32.md
# multicycle_ctrl32

Multi-cycle main controller for the 32-bit MIPS-subset CPU. It replaces the single-cycle `control32` decoder when the datapath shares one ALU and one memory port across cycles. It sequences fetch, decode, execute, memory and write-back as a Moore FSM, stalls on a memory-ready handshake, flags unsupported opcodes, and counts retired instructions. It sits between the instruction register (Opcode/funct source) and the shared PC/ALU/memory/register-file datapath.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- Opcode  in  6  IR[31:26], stable from DECODE onward
- Function_opcode  in  6  IR[5:0]
- Zero  in  1  ALU zero flag (combinational, current cycle)
- mem_ready  in  1  memory completes access this cycle
- PCWrite  out  1  load PC this cycle
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  load IR (qualified by mem_ready)
- RegDST  out  1  write register select: 1 = rd, 0 = rt
- MemtoReg  out  1  write data select: 1 = MDR
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0 = PC, 1 = reg A
- ALUSrcB  out  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct, 11 = I-type op
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = reg A (JR)
- Jal  out  1  force write register $31, write data PC
- Sftmd  out  1  shift instruction in execute
- I_format  out  1  immediate ALU instruction in execute
- Illegal  out  1  one-cycle pulse on unsupported opcode
- Done  out  1  one-cycle pulse on last cycle of an instruction
- InstrCount  out  CNT_W  retired-instruction count
- State  out  4  current state code (debug)

## Operation
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REXEC 6, RWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11, JR 12. Codes 13–15 are unreachable and return to FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite equal mem_ready. Stay in FETCH while mem_ready=0; go to DECODE otherwise.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 000000 with funct 001000 → JR
  - other 000000 → REXEC
  - 100011 or 101011 → MEMADR
  - 000100 or 000101 → BRANCH
  - 000010 or 000011 → JUMP
  - 001xxx → IEXEC
  - anything else → FETCH, with Illegal=1 and no Done and no count.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD for LW, MEMWR for SW.
- MEMRD: MemRead=1, IorD=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDST=0, Done=1, then FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold until mem_ready; on that cycle Done=1, then FETCH.
- REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10, Sftmd = (funct[5:3]==000). Then RWB.
- RWB: RegWrite=1, RegDST=1, MemtoReg=0, Sftmd held, Done=1, then FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11, I_format=1. Then IWB.
- IWB: RegWrite=1, RegDST=0, I_format held, Done=1, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01.
  - PCWrite = (Opcode==000100 & Zero) | (Opcode==000101 & ~Zero).
  - Done=1, then FETCH.
- JUMP: PCWrite=1, PCSource=10. For opcode 000011 also Jal=1 and RegWrite=1. Done=1, then FETCH.
- JR: ALUSrcA=1, PCWrite=1, PCSource=11, Done=1, then FETCH.
- All outputs not listed for a state are 0.
- InstrCount increments by 1 on every cycle with Done=1 and wraps modulo 2^CNT_W.

## Timing
- Outputs are Moore-decoded from the state register. PCWrite/IRWrite in FETCH, MEMWR Done and BRANCH PCWrite also depend combinationally on mem_ready, Zero and Opcode.
- Reset: on a clock edge with reset=1, State goes to FETCH and InstrCount goes to 0. While reset=1, all outputs are forced to 0. This also aborts any in-flight instruction without a count.
- Latency with mem_ready=1 throughout:
  - LW 5 cycles
  - SW, R-type, ADDI-class 4 cycles
  - BEQ, BNE, J, JAL, JR 3 cycles
  - illegal opcode 2 cycles
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. No strobe drops during the stall.
- Done and Illegal are never asserted in the same cycle. Each is high for exactly one cycle per instruction.

## Test plan
- ADD (Opcode 000000, funct 100000), mem_ready=1 → states 0,1,6,7. RWB has RegWrite=1, RegDST=1. InstrCount goes 0→1 after 4 cycles.
- LW with mem_ready low for 2 cycles in FETCH and 1 cycle in MEMRD → 8 total cycles. MemRead held through the stalls. IRWrite pulses exactly once.
- BEQ with Zero=1 → PCWrite=1, PCSource=01 in BRANCH. BNE with Zero=1 → PCWrite=0. Both take 3 cycles with Done=1.
- JAL (000011) → JUMP state with PCWrite=1, PCSource=10, Jal=1, RegWrite=1. JR (funct 001000) → state 12 with PCSource=11.
- SRL (funct 000010) → Sftmd=1 in REXEC and RWB. Illegal opcode 111111 → DECODE→FETCH, Illegal=1 for 1 cycle, InstrCount unchanged.
- Assert reset during MEMRD stall → next cycle State=0 and InstrCount=0. All outputs are 0 while reset is high.
